// File: rtl/lfsr_prng.sv
// Galois LFSR random-word generator: packs OUT_BITS generated bits into a word
// and hands it out over a valid/ready handshake, with zero-seed and wrap flags.
module lfsr_prng #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  TAPS         = 32'h8020_0003,
  parameter int unsigned       OUT_BITS     = 8,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set,
  input  logic [WIDTH-1:0]    set_value,
  input  logic                enable,
  input  logic                rand_ready,
  output logic                rand_valid,
  output logic [OUT_BITS-1:0] rand_out,
  output logic [WIDTH-1:0]    state,
  output logic                seed_fixup,
  output logic                period_wrap
);

  localparam int unsigned      CNT_W    = $clog2(OUT_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_BITS - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } fsm_e;

  fsm_e                fsm_q,     fsm_d;
  logic [WIDTH-1:0]    state_q,   state_d;
  logic [WIDTH-1:0]    seed_q,    seed_d;
  logic [OUT_BITS-1:0] word_q,    word_d;
  logic [OUT_BITS-1:0] rand_q,    rand_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                valid_q,   valid_d;
  logic                fixup_q,   fixup_d;
  logic                wrap_q,    wrap_d;
  logic [WIDTH-1:0]    step_s;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    if (s[0]) begin
      return (s >> 1'b1) ^ TAPS;
    end else begin
      return s >> 1'b1;
    end
  endfunction

  // Next-state logic: seed load, LFSR stepping / word assembly, handshake FSM.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    seed_d    = seed_q;
    word_d    = word_q;
    rand_d    = rand_q;
    bit_cnt_d = bit_cnt_q;
    fixup_d   = 1'b0;
    wrap_d    = 1'b0;
    step_s    = lfsr_step(state_q);

    if (set) begin
      // A held word offered with ready high is already consumed at this edge,
      // so a load simply drops whatever is pending.
      if (set_value == {WIDTH{1'b0}}) begin
        state_d = DEFAULT_SEED;
        seed_d  = DEFAULT_SEED;
        fixup_d = 1'b1;
      end else begin
        state_d = set_value;
        seed_d  = set_value;
      end
      word_d    = {OUT_BITS{1'b0}};
      bit_cnt_d = {CNT_W{1'b0}};
      fsm_d     = FILL;
    end else begin
      case (fsm_q)
        FILL: begin
          if (enable) begin
            state_d                = step_s;
            word_d                 = word_q >> 1'b1;
            word_d[OUT_BITS-1]     = state_q[0];
            wrap_d                 = (step_s == seed_q);
            if (bit_cnt_q == LAST_CNT) begin
              rand_d    = word_d;
              bit_cnt_d = {CNT_W{1'b0}};
              fsm_d     = HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = state_q;
            word_d  = word_q;
          end
        end
        HOLD: begin
          if (rand_ready) begin
            fsm_d = FILL;
          end else begin
            fsm_d = HOLD;
          end
        end
        default: begin
          fsm_d = FILL;
        end
      endcase
    end

    valid_d = (fsm_d == HOLD);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= FILL;
      state_q   <= DEFAULT_SEED;
      seed_q    <= DEFAULT_SEED;
      word_q    <= {OUT_BITS{1'b0}};
      rand_q    <= {OUT_BITS{1'b0}};
      bit_cnt_q <= {CNT_W{1'b0}};
      valid_q   <= 1'b0;
      fixup_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      seed_q    <= seed_d;
      word_q    <= word_d;
      rand_q    <= rand_d;
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= valid_d;
      fixup_q   <= fixup_d;
      wrap_q    <= wrap_d;
    end
  end

  assign rand_valid  = valid_q;
  assign rand_out    = rand_q;
  assign state       = state_q;
  assign seed_fixup  = fixup_q;
  assign period_wrap = wrap_q;

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
- Parametrised Galois LFSR pseudo-random generator for the genetic engine.
- Successor to the fixed 32-bit seedable LFSR; adds configurable width and polynomial, multi-bit output words, a valid/ready handshake, zero-seed lock-up protection and period-wrap detection.
- Feeds random words to the mutation/crossover selectors.

Parameters:
- WIDTH, 32, LFSR state width (≥ 3).
- TAPS, 32'h80200003, Galois feedback mask; WIDTH bits wide; bit WIDTH-1 must be set.
- OUT_BITS, 8, random bits per output word (1..WIDTH).
- DEFAULT_SEED, 1, non-zero seed applied at reset and when a zero seed is requested.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- set  in  1  load seed this cycle.
- set_value  in  WIDTH  seed value.
- enable  in  1  allow LFSR stepping while in FILL.
- rand_ready  in  1  consumer accepts rand_out.
- rand_valid  out  1  rand_out holds a complete word.
- rand_out  out  OUT_BITS  random word.
- state  out  WIDTH  current LFSR state.
- seed_fixup  out  1  one-cycle pulse: zero seed replaced by DEFAULT_SEED.
- period_wrap  out  1  one-cycle pulse: state returned to the last loaded seed.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=DEFAULT_SEED, seed_reg=DEFAULT_SEED, FSM=FILL, bit_cnt=0.
  - rand_out=0, rand_valid=0, seed_fixup=0, period_wrap=0.
  - rst overrides set and all other inputs.
- Step rule:
  - b = state[0].
  - Next state = (state>>1) ^ (b ? TAPS : 0).
  - b is the generated bit.
- FSM FILL:
  - Each cycle with enable=1, perform one step.
  - Shift b into the word so that the first generated bit ends in rand_out[0]: word = {b, word[OUT_BITS-1:1]}.
  - bit_cnt increments.
  - On the OUT_BITS-th step, bit_cnt clears and FSM goes to HOLD; rand_valid=1 from the next cycle.
  - enable=0: no step; state and word are held.
- FSM HOLD:
  - LFSR frozen; rand_out stable while rand_valid=1.
  - rand_valid & rand_ready at an edge is a transfer: rand_valid=0 next cycle, FSM=FILL.
  - Throughput: one word per OUT_BITS+1 cycles when enable=1 and ready is held high.
- rand_out updates only on word completion.
  - rand_out is registered.
  - No combinational path from inputs to outputs.
- set=1, not in reset:
  - set_value≠0: state=seed_reg=set_value.
  - set_value==0: state=seed_reg=DEFAULT_SEED; seed_fixup=1 for one cycle.
  - Any partial word is discarded; bit_cnt=0, FSM=FILL, rand_valid=0 next cycle.
  - set has priority over stepping in the same cycle.
- set during HOLD with rand_ready=1: the transfer of the held word counts (consumer takes the old word); then seed-load rules apply.
- period_wrap:
  - Pulses the cycle after a step whose next state equals seed_reg.
  - Not asserted on the load itself.
  - Maximal-length TAPS yields a pulse every 2^WIDTH-1 steps.
- State never becomes 0 via stepping; zero is reachable only through set, which is blocked by the fixup.
- Steps, counts and shifts are unsigned and modulo their widths.
- bit_cnt is $clog2(OUT_BITS+1) bits.

Test Plan:
- Reset then seed: WIDTH=8, TAPS=8'hB8, OUT_BITS=4, DEFAULT_SEED=1; rst 2 cycles, enable=1, rand_ready=1.
  - First word: rand_out=4'h1 valid on cycle 5 after rst release; state=8'h17.
  - Second word: rand_out=4'h7; state=8'h64.
- Backpressure: same config, rand_ready=0 for 10 cycles after the first valid.
  - rand_valid and rand_out=4'h1 stay stable; state stays 8'h17.
  - Raise ready: transfer occurs; next word is 4'h7.
- Zero seed: set=1, set_value=0 mid-FILL (bit_cnt=2).
  - seed_fixup pulses once; state=8'h01; partial word dropped.
  - Next word is 4'h1.
- Period: WIDTH=8, TAPS=8'hB8, seed 8'h01, enable=1, ready=1.
  - Count steps between period_wrap pulses = 255 exactly.
  - No state ever 0.
- Enable gating and set/handshake collision:
  - Toggle enable every other cycle: word completes after 2·OUT_BITS cycles, same values.
  - set with a HOLD transfer in the same cycle: old word consumed once; rand_valid=0 next cycle.
- rst asserted mid-HOLD with set=1: all outputs return to reset values; state=DEFAULT_SEED; set ignored.
